cpu_step_ctrl: RTL and testbench

Parametrised run/step controller between a raw front-panel push button and the CPU clock-enable. It synchronises and debounces the button, detects presses, and turns each press into one of four execution modes: hold, single step, N-step burst, or free run. It drives a registered one-cycle-granular `cpu_en` to the CPU core and keeps a count of executed steps for the 7-segment display path.

---
 rtl/cpu_step_ctrl_pkg.sv | 18 +
 rtl/cpu_step_ctrl_if.sv | 30 +++
 rtl/cpu_step_ctrl_debounce.sv | 59 +++++
 rtl/cpu_step_ctrl.sv | 86 ++++++++
 tb/tb_cpu_step_ctrl.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_step_ctrl_pkg.sv
// Shared definitions for the run/step controller.
//   MODE_*       : encodings of the 2-bit execution mode input
//   step_state_t : controller FSM state (StIdle must stay at 0)
package cpu_step_pkg;

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_STEP  = 2'b01;
  localparam logic [1:0] MODE_BURST = 2'b10;
  localparam logic [1:0] MODE_RUN   = 2'b11;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStep  = 2'd1,
    StBurst = 2'd2,
    StRun   = 2'd3
  } step_state_t;

endpackage

// File: rtl/cpu_step_ctrl_if.sv
// Front-panel / CPU-enable bundle of the run/step controller.
//   button, enable, start, mode, burst_len : towards the controller
//   cpu_en, busy, db_button, step_cnt      : from the controller
// master = panel/test side, slave = controller side.
interface cpu_step_ctrl_if #(
  parameter int unsigned BURST_W = 8,
  parameter int unsigned CNT_W   = 16
);
  import cpu_step_pkg::*;

  logic               button;
  logic               enable;
  logic               start;
  logic [1:0]         mode;
  logic [BURST_W-1:0] burst_len;
  logic               cpu_en;
  logic               busy;
  logic               db_button;
  logic [CNT_W-1:0]   step_cnt;

  modport master (
    output button, enable, start, mode, burst_len,
    input  cpu_en, busy, db_button, step_cnt
  );

  modport slave (
    input  button, enable, start, mode, burst_len,
    output cpu_en, busy, db_button, step_cnt
  );
endinterface

// File: rtl/cpu_step_ctrl_debounce.sv
// Button conditioner: two-flop synchroniser, debounce counter and rising-edge
// detector.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   button_i      : raw asynchronous button
//   db_level_o    : debounced level
//   press_o       : one-cycle pulse on each debounced rising edge
module btn_debounce import cpu_step_pkg::*; #(
  parameter int unsigned DB_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic button_i,
  output logic db_level_o,
  output logic press_o
);

  localparam int unsigned CW = $clog2(DB_CYCLES + 1);
  // Compare against DB_CYCLES-1 because the edge that would reach DB_CYCLES
  // is the one that updates the level.
  localparam logic [CW-1:0] CntLast = CW'(DB_CYCLES - 1);

  logic          sync_q, btn_s_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          db_q, db_d;
  logic          db_prev_q;

  always_comb begin
    cnt_d = cnt_q;
    db_d  = db_q;
    if (btn_s_q == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntLast) begin
      cnt_d = '0;
      db_d  = btn_s_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q    <= 1'b0;
      btn_s_q   <= 1'b0;
      cnt_q     <= '0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
    end else begin
      sync_q    <= button_i;
      btn_s_q   <= sync_q;
      cnt_q     <= cnt_d;
      db_q      <= db_d;
      db_prev_q <= db_q;
    end
  end

  assign db_level_o = db_q;
  assign press_o    = db_q & ~db_prev_q;

endmodule

// File: rtl/cpu_step_ctrl.sv
// Run/step controller: turns debounced button presses into hold, single
// step, N-step burst or free-run CPU clock-enable, and counts executed steps.
//   clk       : system clock
//   reset_cpu : asynchronous active-low reset
//   ctrl_io   : slave side of cpu_step_ctrl_if (button/mode in, cpu_en out)
// BURST_W and CNT_W must match the connected interface instance.
module cpu_step_ctrl import cpu_step_pkg::*; #(
  parameter int unsigned DB_CYCLES = 16,
  parameter int unsigned BURST_W   = 8,
  parameter int unsigned CNT_W     = 16
) (
  input logic           clk,
  input logic           reset_cpu,
  cpu_step_ctrl_if.slave ctrl_io
);

  logic               db_level;
  logic               press;
  step_state_t        state_q, state_d;
  logic [BURST_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0]   step_cnt_q;

  btn_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_debounce (
    .clk_i      (clk),
    .rst_ni     (reset_cpu),
    .button_i   (ctrl_io.button),
    .db_level_o (db_level),
    .press_o    (press)
  );

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    if (!ctrl_io.enable) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Presses while not armed are dropped, never queued.
          if (press && ctrl_io.start) begin
            case (ctrl_io.mode)
              MODE_STEP: state_d = StStep;
              MODE_BURST: begin
                if (ctrl_io.burst_len != '0) begin
                  state_d     = StBurst;
                  remaining_d = ctrl_io.burst_len;
                end
              end
              MODE_RUN: state_d = StRun;
              default:  state_d = StIdle;
            endcase
          end
        end
        StStep: state_d = StIdle;
        StBurst: begin
          remaining_d = remaining_q - BURST_W'(1);
          // A press on the final cycle is consumed by the exit.
          if (press || remaining_q == BURST_W'(1)) state_d = StIdle;
        end
        StRun: begin
          if (press || ctrl_io.mode != MODE_RUN) state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_cpu) begin
    if (!reset_cpu) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      step_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      if (state_q != StIdle) step_cnt_q <= step_cnt_q + CNT_W'(1);
    end
  end

  assign ctrl_io.cpu_en    = (state_q != StIdle);
  assign ctrl_io.busy      = (state_q != StIdle);
  assign ctrl_io.db_button = db_level;
  assign ctrl_io.step_cnt  = step_cnt_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Self-checking bench for cpu_step_ctrl with DB_CYCLES=4. A second instance
// with a 4-bit step counter shares the stimulus for the wrap check.
module tb_cpu_step_ctrl;
  import cpu_step_pkg::*;

  localparam int unsigned DB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       button = 1'b0;
  logic       enable = 1'b1;
  logic       start = 1'b1;
  logic [1:0] mode = MODE_HOLD;
  logic [7:0] burst_len = 8'd0;

  int n_cmp = 0;
  int n_bad = 0;
  int en_total = 0;
  int db_rise = 0;
  logic db_prev = 1'b0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  cpu_step_ctrl_if #(.BURST_W(8), .CNT_W(16)) bus_w ();
  cpu_step_ctrl_if #(.BURST_W(8), .CNT_W(4))  bus_n ();

  assign bus_w.button = button;    assign bus_n.button = button;
  assign bus_w.enable = enable;    assign bus_n.enable = enable;
  assign bus_w.start = start;      assign bus_n.start = start;
  assign bus_w.mode = mode;        assign bus_n.mode = mode;
  assign bus_w.burst_len = burst_len;
  assign bus_n.burst_len = burst_len;

  cpu_step_ctrl #(.DB_CYCLES(DB), .BURST_W(8), .CNT_W(16)) dut (
    .clk       (clk),
    .reset_cpu (rst_n),
    .ctrl_io   (bus_w)
  );

  cpu_step_ctrl #(.DB_CYCLES(DB), .BURST_W(8), .CNT_W(4)) dut_n (
    .clk       (clk),
    .reset_cpu (rst_n),
    .ctrl_io   (bus_n)
  );

  always @(negedge clk) begin
    if (bus_w.cpu_en === 1'b1) en_total <= en_total + 1;
    db_prev <= bus_w.db_button;
    if (bus_w.db_button === 1'b1 && db_prev === 1'b0) db_rise <= db_rise + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_hold(input int hold);
    button = 1'b1;
    tick(hold);
    button = 1'b0;
    tick(12);
  endtask

  typedef struct {
    logic [1:0] mode;
    logic [7:0] len;
    logic       en;
    logic       st;
    int         exp_en;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int base, base2, first, dbfirst, found;

    vecs[0] = '{MODE_STEP,  8'd0, 1'b1, 1'b1, 1};
    vecs[1] = '{MODE_BURST, 8'd5, 1'b1, 1'b1, 5};
    vecs[2] = '{MODE_BURST, 8'd0, 1'b1, 1'b1, 0};
    vecs[3] = '{MODE_HOLD,  8'd9, 1'b1, 1'b1, 0};
    vecs[4] = '{MODE_STEP,  8'd0, 1'b1, 1'b0, 0};
    vecs[5] = '{MODE_BURST, 8'd3, 1'b0, 1'b1, 0};
    vecs[6] = '{MODE_BURST, 8'd1, 1'b1, 1'b1, 1};
    vecs[7] = '{MODE_RUN,   8'd0, 1'b0, 1'b0, 0};

    // Reset state
    tick(3);
    check("reset cpu_en", {31'd0, bus_w.cpu_en}, 0);
    check("reset busy", {31'd0, bus_w.busy}, 0);
    check("reset db_button", {31'd0, bus_w.db_button}, 0);
    check("reset step_cnt", {16'd0, bus_w.step_cnt}, 0);
    check("reset step_cnt narrow", {28'd0, bus_n.step_cnt}, 0);
    rst_n = 1'b1;
    tick(2);

    // Table-driven presses
    for (int i = 0; i < 8; i++) begin
      mode = vecs[i].mode;
      burst_len = vecs[i].len;
      enable = vecs[i].en;
      start = vecs[i].st;
      base = en_total;
      press_hold(20);
      check($sformatf("vec%0d cpu_en cycles", i), en_total - base, vecs[i].exp_en);
      exp_cnt += vecs[i].exp_en;
      check($sformatf("vec%0d step_cnt", i), {16'd0, bus_w.step_cnt}, exp_cnt);
      enable = 1'b1;
      start = 1'b1;
      tick(2);
    end

    // Single-step latency: raw edge before edge 1, db at edge 6, cpu_en at 7
    mode = MODE_STEP;
    base = en_total;
    first = 0;
    dbfirst = 0;
    button = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (first == 0 && bus_w.cpu_en === 1'b1) first = i;
      if (dbfirst == 0 && bus_w.db_button === 1'b1) dbfirst = i;
    end
    button = 1'b0;
    tick(12);
    check("step db_button latency", dbfirst, 6);
    check("step cpu_en latency", first, 7);
    check("step cpu_en cycles", en_total - base, 1);
    exp_cnt += 1;
    check("step step_cnt", {16'd0, bus_w.step_cnt}, exp_cnt);

    // Bounce: three short pulses then stable high
    base = en_total;
    base2 = db_rise;
    for (int i = 0; i < 3; i++) begin
      button = 1'b1;
      tick(2);
      button = 1'b0;
      tick(2);
    end
    press_hold(20);
    check("bounce db rises", db_rise - base2, 1);
    check("bounce cpu_en cycles", en_total - base, 1);
    exp_cnt += 1;

    // Enable dropped mid-burst
    mode = MODE_BURST;
    burst_len = 8'd10;
    base = en_total;
    found = 0;
    button = 1'b1;
    for (int i = 0; i < 20 && found == 0; i++) begin
      tick(1);
      if (bus_w.cpu_en === 1'b1) found = 1;
    end
    check("burst10 started", found, 1);
    tick(3);
    enable = 1'b0;
    tick(1);
    check("enable drop cpu_en", {31'd0, bus_w.cpu_en}, 0);
    check("enable drop busy", {31'd0, bus_w.busy}, 0);
    enable = 1'b1;
    button = 1'b0;
    tick(12);
    check("enable drop cycles", en_total - base, 4);
    exp_cnt += 4;
    check("enable drop step_cnt", {16'd0, bus_w.step_cnt}, exp_cnt);

    // Press with start low is not replayed later
    mode = MODE_STEP;
    start = 1'b0;
    base = en_total;
    press_hold(20);
    start = 1'b1;
    tick(20);
    check("start replay cycles", en_total - base, 0);

    // Free run, then abort by second press
    mode = MODE_RUN;
    press_hold(6);
    base2 = en_total;
    tick(30);
    check("run continuous", en_total - base2, 30);
    button = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      tick(1);
      if (bus_w.db_button === 1'b1) found = 1;
    end
    check("run 2nd press detected", found, 1);
    check("run cpu_en in press cycle", {31'd0, bus_w.cpu_en}, 1);
    tick(1);
    check("run abort cpu_en", {31'd0, bus_w.cpu_en}, 0);
    button = 1'b0;
    tick(12);

    // Free run ended by mode change
    mode = MODE_RUN;
    press_hold(6);
    check("run2 active", {31'd0, bus_w.cpu_en}, 1);
    mode = MODE_STEP;
    tick(1);
    check("mode switch cpu_en", {31'd0, bus_w.cpu_en}, 0);
    check("mode switch busy", {31'd0, bus_w.busy}, 0);
    tick(5);
    check("mode switch stays idle", {31'd0, bus_w.cpu_en}, 0);

    // Asynchronous reset mid-run
    mode = MODE_RUN;
    press_hold(6);
    check("run3 active", {31'd0, bus_w.cpu_en}, 1);
    check("run3 step_cnt nonzero", {31'd0, (bus_w.step_cnt != 16'd0)}, 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async rst cpu_en", {31'd0, bus_w.cpu_en}, 0);
    check("async rst busy", {31'd0, bus_w.busy}, 0);
    check("async rst step_cnt", {16'd0, bus_w.step_cnt}, 0);
    check("async rst narrow step_cnt", {28'd0, bus_n.step_cnt}, 0);
    mode = MODE_STEP;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    check("post reset idle", {31'd0, bus_w.cpu_en}, 0);

    // Counter wrap: 17 steps into a 4-bit counter
    mode = MODE_BURST;
    burst_len = 8'd17;
    base = en_total;
    press_hold(30);
    check("wrap burst cycles", en_total - base, 17);
    check("wrap step_cnt 16b", {16'd0, bus_w.step_cnt}, 17);
    check("wrap step_cnt 4b", {28'd0, bus_n.step_cnt}, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
